// File: rtl/line_stream_framer_pkg.sv
// Shared types for the framed pixel stream: FSM states, counter width and
// the stream beat consumed by the line buffer / window chain.
package stream_pkg;

    localparam int CNT_W = 11;
    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        WAIT_LINE,
        ACTIVE,
        LINE_DONE
    } state_t;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             dv;
        logic             line_end;
        logic             frame_start;
    } stream_beat_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                  input logic [CNT_W-1:0] max);
        return (v >= max) ? max : v + 1'b1;
    endfunction

endpackage

// File: rtl/line_stream_framer_if.sv
// Raw DE/VSYNC video in, framed pixel stream plus sticky error flags out.
interface line_stream_framer_if
    import stream_pkg::*;
#(
    parameter int COLORDEPTH = 8
) ();

    logic [COLORDEPTH-1:0] data_i;
    logic                  de_i;
    logic                  vs_i;
    logic                  err_clr_i;
    logic [COLORDEPTH-1:0] data_o;
    logic                  dv_o;
    logic                  line_end_o;
    logic                  frame_start_o;
    logic [CNT_W-1:0]      x_o;
    logic [CNT_W-1:0]      y_o;
    logic                  len_err_o;
    logic                  frame_err_o;

    modport master (
        output data_i, de_i, vs_i, err_clr_i,
        input  data_o, dv_o, line_end_o, frame_start_o, x_o, y_o, len_err_o, frame_err_o
    );

    modport slave (
        input  data_i, de_i, vs_i, err_clr_i,
        output data_o, dv_o, line_end_o, frame_start_o, x_o, y_o, len_err_o, frame_err_o
    );

endinterface

// File: rtl/line_stream_framer_edge_det.sv
// Rising/falling edge detector against a one-cycle registered copy of the input.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_reg <= 1'b0;
        end else begin
            sig_reg <= sig;
        end
    end

    assign rise = sig & ~sig_reg;
    assign fall = ~sig & sig_reg;

endmodule

// File: rtl/line_stream_framer.sv
// Frames raw DE/VSYNC video into dv/line_end/frame_start beats with x/y
// coordinates, clipping lines at SCREENWIDTH and flagging bad lines/frames.
module line_stream_framer
    import stream_pkg::*;
#(
    parameter int COLORDEPTH   = 8,
    parameter int SCREENWIDTH  = 1600,
    parameter int SCREENHEIGHT = 900,
    parameter int LINE_END     = 2048
) (
    input logic                 clk,
    input logic                 rst,
    line_stream_framer_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LINE_END - 1);
    localparam logic [CNT_W-1:0] W_CNT   = CNT_W'(SCREENWIDTH);
    localparam logic [CNT_W-1:0] H_CNT   = CNT_W'(SCREENHEIGHT);

    logic vs_rise, vs_fall_unused;
    logic de_rise, de_fall;

    edge_det u_vs_edge (.clk(clk), .rst(rst), .sig(bus.vs_i), .rise(vs_rise), .fall(vs_fall_unused));
    edge_det u_de_edge (.clk(clk), .rst(rst), .sig(bus.de_i), .rise(de_rise), .fall(de_fall));

    state_t                state_reg;
    logic [CNT_W-1:0]      x_cnt_reg;
    logic [CNT_W-1:0]      y_cnt_reg;
    logic                  armed_reg;
    logic [COLORDEPTH-1:0] data_reg;
    logic                  dv_reg;
    logic                  line_end_reg;
    logic                  frame_start_reg;
    logic [CNT_W-1:0]      x_reg;
    logic [CNT_W-1:0]      y_reg;
    logic                  len_err_reg;
    logic                  frame_err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= WAIT_FRAME;
            x_cnt_reg       <= '0;
            y_cnt_reg       <= '0;
            armed_reg       <= 1'b0;
            data_reg        <= '0;
            dv_reg          <= 1'b0;
            line_end_reg    <= 1'b0;
            frame_start_reg <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
            len_err_reg     <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            dv_reg          <= 1'b0;
            line_end_reg    <= 1'b0;
            frame_start_reg <= 1'b0;
            // Later set assignments in this block override the clear.
            if (bus.err_clr_i) begin
                len_err_reg   <= 1'b0;
                frame_err_reg <= 1'b0;
            end
            case (state_reg)
                WAIT_FRAME: begin
                    if (vs_rise) begin
                        state_reg <= WAIT_LINE;
                        y_cnt_reg <= '0;
                        armed_reg <= 1'b1;
                    end
                end
                WAIT_LINE, LINE_DONE: begin
                    if (vs_rise) begin
                        if (y_cnt_reg != H_CNT && y_cnt_reg != '0) begin
                            frame_err_reg <= 1'b1;
                        end
                        y_cnt_reg <= '0;
                        armed_reg <= 1'b1;
                        state_reg <= WAIT_LINE;
                    end else if (de_rise) begin
                        // A burst already high at a VSYNC rise is skipped until de_i falls.
                        state_reg       <= ACTIVE;
                        data_reg        <= bus.data_i;
                        dv_reg          <= 1'b1;
                        x_reg           <= '0;
                        y_reg           <= y_cnt_reg;
                        frame_start_reg <= armed_reg;
                        armed_reg       <= 1'b0;
                        x_cnt_reg       <= CNT_W'(1);
                    end else begin
                        state_reg <= WAIT_LINE;
                    end
                end
                ACTIVE: begin
                    if (vs_rise || de_fall) begin
                        state_reg    <= LINE_DONE;
                        line_end_reg <= 1'b1;
                        if (x_cnt_reg != W_CNT) begin
                            len_err_reg <= 1'b1;
                        end
                        if (vs_rise) begin
                            frame_err_reg <= 1'b1;
                            y_cnt_reg     <= '0;
                            armed_reg     <= 1'b1;
                        end else begin
                            y_cnt_reg <= sat_inc(y_cnt_reg, CNT_MAX);
                        end
                    end else begin
                        if (x_cnt_reg < W_CNT) begin
                            data_reg        <= bus.data_i;
                            dv_reg          <= 1'b1;
                            x_reg           <= x_cnt_reg;
                            y_reg           <= y_cnt_reg;
                            frame_start_reg <= armed_reg;
                            armed_reg       <= 1'b0;
                        end
                        x_cnt_reg <= sat_inc(x_cnt_reg, CNT_MAX);
                    end
                end
                default: state_reg <= WAIT_FRAME;
            endcase
        end
    end

    assign bus.data_o        = data_reg;
    assign bus.dv_o          = dv_reg;
    assign bus.line_end_o    = line_end_reg;
    assign bus.frame_start_o = frame_start_reg;
    assign bus.x_o           = x_reg;
    assign bus.y_o           = y_reg;
    assign bus.len_err_o     = len_err_reg;
    assign bus.frame_err_o   = frame_err_reg;

endmodule

// File: tb/tb_line_stream_framer.sv
// Directed bench for line_stream_framer on a reduced 16x4 screen.
module tb_line_stream_framer;
    import stream_pkg::*;

    localparam int W = 16;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_stream_framer_if #(.COLORDEPTH(8)) bus ();

    line_stream_framer #(
        .COLORDEPTH  (8),
        .SCREENWIDTH (W),
        .SCREENHEIGHT(H),
        .LINE_END    (2048)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int dv_cnt, le_cnt, fs_cnt, mon_x;
    int first_cyc, first_y, le_cyc, after_le_cyc, after_le_x;
    int last_x, last_y, fs_x, fs_y;
    bit prev_le;

    typedef struct {
        bit vs;
        int len;
        bit clr;
        int exp_dv;
        int exp_last_x;
        int exp_y;
        int exp_fs;
        int exp_len;
        int exp_frame;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        dv_cnt = 0; le_cnt = 0; fs_cnt = 0; mon_x = 0;
        first_cyc = -1; first_y = -1; le_cyc = -1;
        after_le_cyc = -1; after_le_x = -1;
        last_x = -1; last_y = -1; fs_x = -1; fs_y = -1;
        prev_le = 1'b0;
    endtask

    // Drive one cycle, then sample the outputs 1 ns after the edge.
    task automatic step(input logic de, input logic vs, input logic [7:0] d, input logic clr);
        logic [7:0] mx;
        bus.de_i      = de;
        bus.vs_i      = vs;
        bus.data_i    = d;
        bus.err_clr_i = clr;
        @(posedge clk);
        #1;
        cyc++;
        check("le_dv_excl", 32'(bus.line_end_o & bus.dv_o), 0);
        if (bus.dv_o) begin
            mx = 8'(mon_x);
            check("x", 32'(bus.x_o), mon_x);
            check("data", 32'(bus.data_o), 32'(mx ^ 8'hA5));
            if (dv_cnt == 0) begin
                first_cyc = cyc;
                first_y   = int'(bus.y_o);
            end
            if (prev_le && after_le_cyc < 0) begin
                after_le_cyc = cyc;
                after_le_x   = int'(bus.x_o);
            end
            last_x = int'(bus.x_o);
            last_y = int'(bus.y_o);
            dv_cnt++;
            mon_x++;
        end
        if (bus.frame_start_o) begin
            fs_cnt++;
            fs_x = int'(bus.x_o);
            fs_y = int'(bus.y_o);
        end
        if (bus.line_end_o) begin
            le_cnt++;
            if (le_cyc < 0) le_cyc = cyc;
            mon_x = 0;
        end
        prev_le = bus.line_end_o;
    endtask

    task automatic vs_pulse();
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic drive_line(input int len, input int blank);
        for (int i = 0; i < len; i++) step(1'b1, 1'b0, 8'(i) ^ 8'hA5, 1'b0);
        for (int i = 0; i < blank; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic clr_pulse();
        step(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        //         vs  len clr  dv  lastx y  fs len frm
        vecs[0] = '{1'b1, 16, 1'b0, 16, 15, 0, 1, 0, 0};
        vecs[1] = '{1'b0, 16, 1'b0, 16, 15, 1, 0, 0, 0};
        vecs[2] = '{1'b0, 16, 1'b0, 16, 15, 2, 0, 0, 0};
        vecs[3] = '{1'b0, 16, 1'b0, 16, 15, 3, 0, 0, 0};
        vecs[4] = '{1'b1, 20, 1'b1, 16, 15, 0, 1, 1, 0};
        vecs[5] = '{1'b0, 10, 1'b1, 10,  9, 1, 0, 1, 0};
        vecs[6] = '{1'b0, 16, 1'b0, 16, 15, 2, 0, 0, 0};
        vecs[7] = '{1'b1, 16, 1'b1, 16, 15, 0, 1, 0, 1};
        vecs[8] = '{1'b0, 16, 1'b0, 16, 15, 1, 0, 0, 0};

        bus.data_i = 8'h00; bus.de_i = 1'b0; bus.vs_i = 1'b0; bus.err_clr_i = 1'b0;
        clear_mon();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_dv", 32'(bus.dv_o), 0);
        check("rst_le", 32'(bus.line_end_o), 0);
        check("rst_fs", 32'(bus.frame_start_o), 0);
        check("rst_x", 32'(bus.x_o), 0);
        check("rst_y", 32'(bus.y_o), 0);
        check("rst_data", 32'(bus.data_o), 0);
        check("rst_len_err", 32'(bus.len_err_o), 0);
        check("rst_frame_err", 32'(bus.frame_err_o), 0);
        rst = 1'b0;

        // DE without VSYNC emits nothing
        drive_line(16, 3);
        check("no_vs_dv", dv_cnt, 0);
        check("no_vs_le", le_cnt, 0);

        for (int v = 0; v < 9; v++) begin
            clear_mon();
            if (vecs[v].vs) vs_pulse();
            drive_line(vecs[v].len, 3);
            $display("line %0d: len=%0d dv=%0d last_x=%0d y=%0d fs=%0d le=%0d len_err=%0d frame_err=%0d",
                     v, vecs[v].len, dv_cnt, last_x, first_y, fs_cnt, le_cnt,
                     bus.len_err_o, bus.frame_err_o);
            check("vec_dv_cnt", dv_cnt, vecs[v].exp_dv);
            check("vec_last_x", last_x, vecs[v].exp_last_x);
            check("vec_y", first_y, vecs[v].exp_y);
            check("vec_last_y", last_y, vecs[v].exp_y);
            check("vec_fs_cnt", fs_cnt, vecs[v].exp_fs);
            if (vecs[v].exp_fs == 1) begin
                check("vec_fs_x", fs_x, 0);
                check("vec_fs_y", fs_y, 0);
            end
            check("vec_le_cnt", le_cnt, 1);
            check("vec_len_err", 32'(bus.len_err_o), vecs[v].exp_len);
            check("vec_frame_err", 32'(bus.frame_err_o), vecs[v].exp_frame);
            if (vecs[v].clr) begin
                clr_pulse();
                check("clr_len_err", 32'(bus.len_err_o), 0);
                check("clr_frame_err", 32'(bus.frame_err_o), 0);
            end
        end

        // Short line, 1-cycle blank, full line back-to-back
        vs_pulse();
        clr_pulse();
        clear_mon();
        drive_line(10, 1);
        drive_line(16, 3);
        $display("b2b: dv=%0d le=%0d le_at=%0d next_dv_at=%0d next_x=%0d len_err=%0d",
                 dv_cnt, le_cnt, le_cyc - first_cyc, after_le_cyc - le_cyc, after_le_x, bus.len_err_o);
        check("b2b_dv_cnt", dv_cnt, 26);
        check("b2b_le_cnt", le_cnt, 2);
        check("b2b_le_offset", le_cyc - first_cyc, 10);
        check("b2b_next_dv_gap", after_le_cyc - le_cyc, 1);
        check("b2b_next_x", after_le_x, 0);
        check("b2b_len_err", 32'(bus.len_err_o), 1);
        check("b2b_frame_err", 32'(bus.frame_err_o), 0);

        // VSYNC rise mid-line
        vs_pulse();
        clr_pulse();
        drive_line(16, 3);
        drive_line(16, 3);
        clear_mon();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(i) ^ 8'hA5, 1'b0);
        step(1'b1, 1'b1, 8'h08 ^ 8'hA5, 1'b0);
        check("abort_le", 32'(bus.line_end_o), 1);
        check("abort_dv", 32'(bus.dv_o), 0);
        check("abort_len_err", 32'(bus.len_err_o), 1);
        check("abort_frame_err", 32'(bus.frame_err_o), 1);
        for (int i = 9; i < 12; i++) step(1'b1, 1'b1, 8'(i) ^ 8'hA5, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        $display("vs_mid: dv=%0d le=%0d len_err=%0d frame_err=%0d",
                 dv_cnt, le_cnt, bus.len_err_o, bus.frame_err_o);
        check("abort_dv_cnt", dv_cnt, 8);
        check("abort_le_cnt", le_cnt, 1);
        clear_mon();
        drive_line(16, 3);
        $display("vs_mid next: dv=%0d fs=%0d fs_x=%0d fs_y=%0d", dv_cnt, fs_cnt, fs_x, fs_y);
        check("abort_next_dv", dv_cnt, 16);
        check("abort_next_fs", fs_cnt, 1);
        check("abort_next_fs_x", fs_x, 0);
        check("abort_next_fs_y", fs_y, 0);

        // Short frame, then VSYNC rising together with DE
        vs_pulse();
        clr_pulse();
        for (int l = 0; l < H - 1; l++) drive_line(16, 3);
        clear_mon();
        step(1'b1, 1'b1, 8'hA5, 1'b0);
        check("simul_dv", 32'(bus.dv_o), 0);
        check("simul_frame_err", 32'(bus.frame_err_o), 1);
        for (int i = 1; i < 6; i++) step(1'b1, 1'b1, 8'(i) ^ 8'hA5, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("simul_burst_dv", dv_cnt, 0);
        drive_line(16, 3);
        $display("simul: dv=%0d fs=%0d first_y=%0d frame_err=%0d", dv_cnt, fs_cnt, first_y, bus.frame_err_o);
        check("simul_next_dv", dv_cnt, 16);
        check("simul_next_fs", fs_cnt, 1);
        check("simul_next_y", first_y, 0);
        check("simul_next_le", le_cnt, 1);

        // Asynchronous reset mid-line
        clear_mon();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(i) ^ 8'hA5, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("arst_dv", 32'(bus.dv_o), 0);
        check("arst_le", 32'(bus.line_end_o), 0);
        check("arst_fs", 32'(bus.frame_start_o), 0);
        check("arst_x", 32'(bus.x_o), 0);
        check("arst_y", 32'(bus.y_o), 0);
        check("arst_data", 32'(bus.data_o), 0);
        check("arst_frame_err", 32'(bus.frame_err_o), 0);
        check("arst_len_err", 32'(bus.len_err_o), 0);
        #1 rst = 1'b0;
        for (int i = 5; i < 16; i++) step(1'b1, 1'b0, 8'(i) ^ 8'hA5, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        drive_line(16, 3);
        $display("arst: dv=%0d le=%0d", dv_cnt, le_cnt);
        check("arst_after_dv", dv_cnt, 5);
        check("arst_after_le", le_cnt, 0);
        vs_pulse();
        clear_mon();
        drive_line(16, 3);
        $display("arst resume: dv=%0d fs=%0d y=%0d", dv_cnt, fs_cnt, first_y);
        check("arst_resume_dv", dv_cnt, 16);
        check("arst_resume_fs", fs_cnt, 1);
        check("arst_resume_y", first_y, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
